load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: aligns core loads/stores onto a word-wide bus,
// stalling the pipeline until bus_ack or a timeout fault.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [9:0]  r_cnt;
  logic [1:0]  r_lane, r_size;
  logic        r_uns, r_we;
  logic [3:0]  r_be;
  logic [31:0] r_baddr, r_bwdata, r_rdata;

  logic        w_req, w_misalign, w_legal, w_illegal, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_bwdata, w_sh, w_ld;

  assign w_req      = memread ^ memwrite;
  assign w_misalign = (size == 2'b11)
                    | ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00));
  assign w_legal    = w_req & ~w_misalign;
  assign w_illegal  = (memread & memwrite) | (w_req & w_misalign);
  assign w_timeout  = (r_state == ACCESS) & ~bus_ack & (r_cnt == TO_LAST);

  always_comb begin
    w_be     = 4'b0000;
    w_bwdata = wdata;
    unique case (size)
      2'b00: begin
        w_be     = 4'b0001 << addr[1:0];
        w_bwdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be     = addr[1] ? 4'b1100 : 4'b0011;
        w_bwdata = {2{wdata[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend.
  assign w_sh = bus_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_ld = w_sh;
    unique case (r_size)
      2'b00: w_ld = {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
      2'b01: w_ld = {{16{~r_uns & w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    fault  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_legal) begin
          stall  = 1'b1;
          w_next = ACCESS;
        end else if (w_illegal) begin
          fault = 1'b1;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (bus_ack) begin
          w_next = DONE;
        end else if (w_timeout) begin
          fault  = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_lane   <= '0;
      r_size   <= '0;
      r_uns    <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_baddr  <= '0;
      r_bwdata <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_legal) begin
          r_cnt    <= '0;
          r_lane   <= addr[1:0];
          r_size   <= size;
          r_uns    <= unsigned_ld;
          r_we     <= memwrite;
          r_be     <= w_be;
          r_baddr  <= {addr[31:2], 2'b00};
          r_bwdata <= w_bwdata;
        end else if (w_illegal) begin
          r_rdata <= '0;
        end
      end else if (r_state == ACCESS) begin
        if (bus_ack) begin
          if (!r_we) r_rdata <= w_ld;
        end else if (w_timeout) begin
          r_rdata <= '0;
        end else begin
          r_cnt <= r_cnt + 10'd1;
        end
      end
    end
  end

  assign rdata     = r_rdata;
  assign bus_req   = (r_state == ACCESS);
  assign bus_we    = r_we;
  assign bus_be    = r_be;
  assign bus_addr  = r_baddr;
  assign bus_wdata = r_bwdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus
// hand-written latency, timeout and reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, unsigned_ld, bus_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, fault, bus_req, bus_we;
  logic [3:0]  bus_be;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .memread(memread), .memwrite(memwrite),
    .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    logic        bad;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t v [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memread = 0; memwrite = 0; size = 0; unsigned_ld = 0;
    addr = 0; wdata = 0;
  endtask

  task automatic start(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    memread = rd; memwrite = wr; size = sz;
    unsigned_ld = uns; addr = a; wdata = d;
  endtask

  task automatic run_vec(input int i, input vec_t t);
    string s;
    s = $sformatf("v%0d", i);
    @(negedge clk);
    start(t.rd, t.wr, t.sz, t.uns, t.addr, t.wdata);
    #1;
    chk({s, " idle stall"}, 32'(stall), 32'(!t.bad));
    chk({s, " idle fault"}, 32'(fault), 32'(t.bad));
    chk({s, " idle req"}, 32'(bus_req), 32'd0);
    @(negedge clk);
    idle_inputs();
    if (t.bad) begin
      #1;
      chk({s, " bad rdata"}, rdata, t.rdata);
      chk({s, " bad req"}, 32'(bus_req), 32'd0);
      chk({s, " bad stall"}, 32'(stall), 32'd0);
    end else begin
      bus_ack = 1; bus_rdata = t.brdata;
      #1;
      chk({s, " req"}, 32'(bus_req), 32'd1);
      chk({s, " stall"}, 32'(stall), 32'd1);
      chk({s, " we"}, 32'(bus_we), 32'(t.we));
      chk({s, " be"}, 32'(bus_be), 32'(t.be));
      chk({s, " addr"}, bus_addr, t.baddr);
      chk({s, " wdata"}, bus_wdata, t.bwdata);
      @(negedge clk);
      bus_ack = 0; bus_rdata = 0;
      #1;
      chk({s, " done stall"}, 32'(stall), 32'd0);
      chk({s, " done req"}, 32'(bus_req), 32'd0);
      chk({s, " done fault"}, 32'(fault), 32'd0);
      chk({s, " rdata"}, rdata, t.rdata);
    end
  endtask

  initial begin
    v[0]  = '{1,0,2'd2,0,32'h10010004,32'h11223344,32'hDEADBEEF,0,0,4'hF,32'h10010004,32'h11223344,32'hDEADBEEF};
    v[1]  = '{1,0,2'd0,0,32'h10010001,32'hAABBCCDD,32'h12347F56,0,0,4'h2,32'h10010000,32'hDDDDDDDD,32'h0000007F};
    v[2]  = '{1,0,2'd0,1,32'h10010002,32'h00000000,32'h00A50000,0,0,4'h4,32'h10010000,32'h00000000,32'h000000A5};
    v[3]  = '{1,0,2'd1,0,32'h10010002,32'h00000000,32'h8001FFFF,0,0,4'hC,32'h10010000,32'h00000000,32'hFFFF8001};
    v[4]  = '{1,0,2'd1,1,32'h10010000,32'h00000000,32'h1234F00D,0,0,4'h3,32'h10010000,32'h00000000,32'h0000F00D};
    v[5]  = '{0,1,2'd1,0,32'h10010002,32'h0000BEEF,32'hFFFFFFFF,0,1,4'hC,32'h10010000,32'hBEEFBEEF,32'h0000F00D};
    v[6]  = '{0,1,2'd0,0,32'h10010003,32'h12345678,32'hFFFFFFFF,0,1,4'h8,32'h10010000,32'h78787878,32'h0000F00D};
    v[7]  = '{0,1,2'd2,0,32'h20000008,32'hCAFEF00D,32'h00000000,0,1,4'hF,32'h20000008,32'hCAFEF00D,32'h0000F00D};
    v[8]  = '{1,0,2'd2,0,32'h10010001,32'h0,32'h0,1,0,4'h0,32'h0,32'h0,32'h00000000};
    v[9]  = '{1,0,2'd0,0,32'h10010003,32'h0,32'h80FFFFFF,0,0,4'h8,32'h10010000,32'h00000000,32'hFFFFFF80};
    v[10] = '{1,1,2'd2,0,32'h10010000,32'h0,32'h0,1,0,4'h0,32'h0,32'h0,32'h00000000};
    v[11] = '{1,0,2'd3,0,32'h10010000,32'h0,32'h0,1,0,4'h0,32'h0,32'h0,32'h00000000};
    v[12] = '{0,1,2'd1,0,32'h10010001,32'h0,32'h0,1,0,4'h0,32'h0,32'h0,32'h00000000};

    reset = 1; bus_ack = 0; bus_rdata = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst rdata", rdata, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst req", 32'(bus_req), 32'd0);
    chk("rst we", 32'(bus_we), 32'd0);
    chk("rst be", 32'(bus_be), 32'd0);
    chk("rst addr", bus_addr, 32'd0);
    chk("rst wdata", bus_wdata, 32'd0);
    reset = 0;

    for (int i = 0; i < 13; i++) run_vec(i, v[i]);

    // Signed byte load, ack in 3rd ACCESS cycle: 4 stall cycles.
    @(negedge clk);
    start(1, 0, 2'd0, 0, 32'h10010003, 32'h0);
    #1 chk("lat stall c1", 32'(stall), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 4) begin bus_ack = 1; bus_rdata = 32'h80FFFFFF; end
      #1;
      chk($sformatf("lat stall c%0d", c), 32'(stall), 32'd1);
      chk($sformatf("lat req c%0d", c), 32'(bus_req), 32'd1);
      chk($sformatf("lat be c%0d", c), 32'(bus_be), 32'h8);
    end
    @(negedge clk);
    bus_ack = 0; bus_rdata = 0;
    #1;
    chk("lat done stall", 32'(stall), 32'd0);
    chk("lat rdata", rdata, 32'hFFFFFF80);

    // Timeout with no ack: fault in the 4th ACCESS cycle.
    @(negedge clk);
    start(1, 0, 2'd2, 0, 32'h10010008, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("to req a%0d", c), 32'(bus_req), 32'd1);
      chk($sformatf("to fault a%0d", c), 32'(fault), 32'(c == 4));
    end
    @(negedge clk);
    #1;
    chk("to done req", 32'(bus_req), 32'd0);
    chk("to done fault", 32'(fault), 32'd0);
    chk("to done stall", 32'(stall), 32'd0);
    chk("to rdata", rdata, 32'd0);
    @(negedge clk);
    #1 chk("to idle stall", 32'(stall), 32'd0);

    // Ack coinciding with the timeout cycle wins.
    @(negedge clk);
    start(1, 0, 2'd2, 0, 32'h1001000C, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 4) begin bus_ack = 1; bus_rdata = 32'h5A5A0001; end
      #1;
      chk($sformatf("race fault a%0d", c), 32'(fault), 32'd0);
    end
    @(negedge clk);
    bus_ack = 0; bus_rdata = 0;
    #1 chk("race rdata", rdata, 32'h5A5A0001);

    // Reset in the 2nd ACCESS cycle abandons the access.
    @(negedge clk);
    start(1, 0, 2'd2, 0, 32'h10010010, 32'h0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("mrst req", 32'(bus_req), 32'd0);
    chk("mrst stall", 32'(stall), 32'd0);
    chk("mrst fault", 32'(fault), 32'd0);
    chk("mrst rdata", rdata, 32'd0);
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    #1;
    chk("stray stall", 32'(stall), 32'd0);
    chk("stray fault", 32'(fault), 32'd0);
    @(negedge clk);
    bus_ack = 0; bus_rdata = 0;
    #1;
    chk("stray req", 32'(bus_req), 32'd0);
    chk("stray rdata", rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
